sprite_penguin_jump: RTL
========================

// Module: sprite_penguin_jump
// PURPOSE
//  Penguin sprite with button-driven jump physics; feeds penguin colour and hit into the gfx compositor.
//  Syncs jump button and v_sync, debounces per frame, runs GROUND/RISE/FALL FSM once per frame tick.
//  Hit and colour are combinational from i_x/i_y against the registered sprite Y, so there is zero pixel latency.
// PARAMETERS
//  X_POS      96   fixed sprite left column (px)
//  GROUND_Y   400  sprite top row when standing (px)
//  SPR_W      32   sprite width (px)
//  SPR_H      32   sprite height (px)
//  JUMP_V0    12   initial upward velocity (px/frame), 1..255
//  GRAVITY    1    velocity change per frame (px/frame^2), >=1
//  MAX_FALL   15   fall velocity cap (px/frame)
//  DEB_FRAMES 3    consecutive equal frame samples required to change debounced button
// PORTS
//  i_clk         in   1   pixel clock
//  i_rst_n       in   1   asynchronous active-low reset
//  i_x           in   16  current pixel column
//  i_y           in   16  current pixel row
//  i_v_sync      in   1   vertical sync, active high
//  i_btn_jump    in   1   raw jump button, active high, asynchronous
//  o_red         out  8   sprite red (0 when not hit)
//  o_green       out  8   sprite green (0 when not hit)
//  o_blue        out  8   sprite blue (0 when not hit)
//  o_sprite_hit  out  1   pixel inside sprite box
//  o_airborne    out  1   FSM state != GROUND (registered)
//  o_y_pos       out  16  current sprite top row (registered)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state=GROUND, y=GROUND_Y, vel=0, deb=0, counter=0, pending=0, o_airborne=0.
//  - Reset mid-jump returns the sprite to the ground immediately. Hit/colour stay evaluated against y=GROUND_Y.
//  - i_v_sync and i_btn_jump each pass through a 2-flop synchronizer.
//  - tick = 1-cycle pulse on the rising edge of the synced v_sync, asserted 3 clocks after i_v_sync rises.
//  - All of y, vel, state, the debounce counter and the debounced button change only on tick.
//  - Debounce: on tick, if synced btn != deb, increment cnt; else cnt=0.
//  - When cnt reaches DEB_FRAMES, deb toggles and cnt=0. The deb 0->1 transition is the press event.
//  - Holding the button never re-triggers; a release (DEB_FRAMES low samples) is required before the next press.
//  - GROUND: a press event sets pending. On a tick with pending=1: vel=JUMP_V0, state=RISE, pending=0, y unchanged.
//  - RISE (per tick): y = (y>=vel) ? y-vel : 0; vel = vel-GRAVITY (saturating at 0).
//    When the new vel is 0, state=FALL.
//  - FALL (per tick): v' = min(vel+GRAVITY, MAX_FALL).
//    If y+v' >= GROUND_Y: y=GROUND_Y, vel=0, state=GROUND. Else y=y+v', vel=v'.
//  - Press events while RISE/FALL are discarded (not queued); pending is only set in GROUND.
//  - Arithmetic: y is 16-bit unsigned, vel 8-bit unsigned; y+v' is computed at 17 bits.
//  - hit = (X_POS<=i_x<X_POS+SPR_W) && (y<=i_y<y+SPR_H), compared at 17 bits (no wrap).
//  - Colour: belly (i_x-X_POS in [8,24) and i_y-y in [10,30)) = FF,FF,FF. Rest of box = 20,20,40. Outside = 00,00,00.
// CONFIGURATION
//  PENGUIN_DOUBLE_JUMP_EN defined:
//  - One extra jump is allowed per airtime: a press event in RISE/FALL with used=0 sets vel=JUMP_V0,
//    state=RISE, used=1, y unchanged that tick.
//  - used clears on landing and on reset.
//  PENGUIN_DOUBLE_JUMP_EN undefined: airborne presses are discarded, the used flag does not exist,
//  and behaviour is otherwise identical.
// TESTING
//  - Reset: drop i_rst_n mid-RISE -> same cycle o_airborne=0, o_y_pos=400. Pixel (100,410) -> hit=1, colour 20,20,40.
//  - Single jump (defaults): btn high across ticks 1-3 -> press at tick3, RISE at tick4.
//    Apex y=322 after tick16, FALL ticks 17-28, lands y=400 at tick28 with o_airborne=0.
//  - Bounce: btn high for 2 ticks only -> no jump. Btn held 40 ticks -> exactly one jump.
//  - Airborne press (macro off): second press at tick10 -> ignored, landing still at tick28.
//    Macro on: second press at tick10 -> vel=12, new RISE from the current y, only one extra jump honoured.
//  - Pixel edges with y=400: (95,400)->0, (96,400)->1, (127,431)->1, (128,431)->0, (96,432)->0. (104,410)->FF,FF,FF.
//  - Top clamp (JUMP_V0=255, GROUND_Y=100): y saturates at 0, never wraps, and the sprite lands back at 100.

Source files
------------

// File: rtl/sprite_penguin_jump.sv
// Penguin sprite with button-driven jump physics for the gfx compositor.
// The jump button and v_sync are synchronised. The button is debounced once per frame.
// A GROUND/RISE/FALL state machine advances once per frame tick.
// Hit and colour are combinational from the pixel coordinate against the registered Y.
// Optional feature macro: PENGUIN_DOUBLE_JUMP_EN allows one extra jump per airtime.
module sprite_penguin_jump #(
  parameter int X_POS      = 96,
  parameter int GROUND_Y   = 400,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int JUMP_V0    = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 15,
  parameter int DEB_FRAMES = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_v_sync,
  input  logic        i_btn_jump,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_sprite_hit,
  output logic        o_airborne,
  output logic [15:0] o_y_pos
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  localparam logic [15:0] GY16  = 16'(GROUND_Y);
  localparam logic [7:0]  JV8   = 8'(JUMP_V0);
  localparam logic [7:0]  G8    = 8'(GRAVITY);
  localparam logic [7:0]  MF8   = 8'(MAX_FALL);
  localparam logic [7:0]  DEB_N = 8'(DEB_FRAMES);
  localparam logic [16:0] X_LO  = 17'(X_POS);
  localparam logic [16:0] X_HI  = 17'(X_POS + SPR_W);
  localparam logic [16:0] H17   = 17'(SPR_H);

  // Velocity decrement while rising, saturating at zero.
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v >= G8) ? (v - G8) : 8'd0;
  endfunction

  // Velocity increment while falling, clamped at the terminal fall speed.
  function automatic logic [7:0] fall_vel(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} + {1'b0, G8};
    return (s >= {1'b0, MF8}) ? MF8 : s[7:0];
  endfunction

  logic        vs_s1, vs_s2, vs_s3, tick;
  logic        btn_s1, btn_s2;
  logic        deb;
  logic [7:0]  deb_cnt;
  logic        deb_hit, press, dj_fire;
  state_t      state;
  logic [15:0] y;
  logic [7:0]  vel;
  logic        pending;
  logic [7:0]  rise_v, fall_v;
  logic [15:0] rise_y;
  logic [16:0] fall_sum;
  logic        landed;

  // Two-flop synchronisers and the registered rising-edge detect of v_sync.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_s1  <= 1'b0;
      vs_s2  <= 1'b0;
      vs_s3  <= 1'b0;
      tick   <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      vs_s1  <= i_v_sync;
      vs_s2  <= vs_s1;
      vs_s3  <= vs_s2;
      tick   <= vs_s2 & ~vs_s3;
      btn_s1 <= i_btn_jump;
      btn_s2 <= btn_s1;
    end
  end

  assign deb_hit = (deb_cnt + 8'd1) >= DEB_N;
  assign press   = tick && !deb && btn_s2 && deb_hit;

  // Per-frame debounce: the output flips after DEB_FRAMES consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb     <= 1'b0;
      deb_cnt <= 8'd0;
    end else if (tick) begin
      if (btn_s2 != deb) begin
        if (deb_hit) begin
          deb     <= ~deb;
          deb_cnt <= 8'd0;
        end else begin
          deb_cnt <= deb_cnt + 8'd1;
        end
      end else begin
        deb_cnt <= 8'd0;
      end
    end
  end

  assign rise_v   = sat_dec(vel);
  assign rise_y   = (y >= {8'd0, vel}) ? (y - {8'd0, vel}) : 16'd0;
  assign fall_v   = fall_vel(vel);
  assign fall_sum = {1'b0, y} + {9'd0, fall_v};
  assign landed   = fall_sum >= {1'b0, GY16};

`ifdef PENGUIN_DOUBLE_JUMP_EN
  logic dj_used;
  assign dj_fire = press && !dj_used && (state != GROUND);

  // Tracks whether the single extra jump of this airtime has been spent.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dj_used <= 1'b0;
    end else if (tick) begin
      if (dj_fire) dj_used <= 1'b1;
      else if (state == FALL && landed) dj_used <= 1'b0;
    end
  end
`else
  assign dj_fire = 1'b0;
`endif

  // Jump state machine with registered position, velocity and airborne flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= GROUND;
      y          <= GY16;
      vel        <= 8'd0;
      pending    <= 1'b0;
      o_airborne <= 1'b0;
    end else if (tick) begin
      if (dj_fire) begin
        vel        <= JV8;
        state      <= RISE;
        o_airborne <= 1'b1;
      end else begin
        case (state)
          GROUND: begin
            if (pending) begin
              vel        <= JV8;
              state      <= RISE;
              pending    <= 1'b0;
              o_airborne <= 1'b1;
            end else if (press) begin
              pending <= 1'b1;
            end
          end
          RISE: begin
            y   <= rise_y;
            vel <= rise_v;
            if (rise_v == 8'd0) state <= FALL;
          end
          FALL: begin
            if (landed) begin
              y          <= GY16;
              vel        <= 8'd0;
              state      <= GROUND;
              o_airborne <= 1'b0;
            end else begin
              y   <= fall_sum[15:0];
              vel <= fall_v;
            end
          end
          default: begin
            state      <= GROUND;
            y          <= GY16;
            vel        <= 8'd0;
            o_airborne <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_y_pos = y;

  logic [16:0] px, py, dx, dy, y_lo, y_hi;
  logic        belly;

  assign px    = {1'b0, i_x};
  assign py    = {1'b0, i_y};
  assign y_lo  = {1'b0, y};
  assign y_hi  = y_lo + H17;
  assign dx    = px - X_LO;
  assign dy    = py - y_lo;
  assign o_sprite_hit = (px >= X_LO) && (px < X_HI) && (py >= y_lo) && (py < y_hi);
  assign belly = (dx >= 17'd8) && (dx < 17'd24) && (dy >= 17'd10) && (dy < 17'd30);

  // Penguin palette: white belly patch inside a dark body box.
  always_comb begin
    o_red   = 8'h00;
    o_green = 8'h00;
    o_blue  = 8'h00;
    if (o_sprite_hit) begin
      if (belly) begin
        o_red   = 8'hFF;
        o_green = 8'hFF;
        o_blue  = 8'hFF;
      end else begin
        o_red   = 8'h20;
        o_green = 8'h20;
        o_blue  = 8'h40;
      end
    end
  end

endmodule
